// File: rtl/dds_ui_pkg.sv
// Shared constants and helpers for the DDS key-driven digit editor.
package dds_ui_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  localparam int K_U = 0;
  localparam int K_D = 1;
  localparam int K_L = 2;
  localparam int K_R = 3;

  typedef struct packed {
    logic [MAX_DIGITS*DIGIT_W-1:0] value;
    logic                          ovf;
  } step_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sel_w(input int n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

  // Adds or subtracts one unit at digit 'sel' with ripple carry/borrow;
  // ovf is the carry/borrow left over past the top digit.
  function automatic step_t carry_step(input logic [MAX_DIGITS*DIGIT_W-1:0] value,
                                       input int num_digits, input logic [4:0] radix,
                                       input int sel, input logic down);
    step_t      r;
    logic [4:0] d;
    logic       c;
    r.value = value;
    c       = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i >= sel && i < num_digits && c) begin
        d = {1'b0, value[i*DIGIT_W +: DIGIT_W]};
        if (!down) begin
          if (d + 5'd1 == radix) begin
            r.value[i*DIGIT_W +: DIGIT_W] = '0;
          end else begin
            r.value[i*DIGIT_W +: DIGIT_W] = d[3:0] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 5'd0) begin
            d = radix - 5'd1;
            r.value[i*DIGIT_W +: DIGIT_W] = d[3:0];
          end else begin
            r.value[i*DIGIT_W +: DIGIT_W] = d[3:0] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    r.ovf = c;
    return r;
  endfunction

endpackage

// File: rtl/digit_editor_if.sv
// Key inputs and digit outputs of the digit editor.
interface digit_editor_if #(
  parameter int NUM_DIGITS = 4
);
  import dds_ui_pkg::*;

  localparam int SEL_W = sel_w(NUM_DIGITS);

  // Keys are raw active-low levels, asynchronous to clk; all outputs are
  // registered, changed/limit are single-cycle pulses.
  logic                          KEY_U;
  logic                          KEY_D;
  logic                          KEY_L;
  logic                          KEY_R;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits;
  logic [SEL_W-1:0]              Bit_Sel;
  logic                          changed;
  logic                          limit;

  modport master (output KEY_U, KEY_D, KEY_L, KEY_R,
                  input  digits, Bit_Sel, changed, limit);
  modport slave  (input  KEY_U, KEY_D, KEY_L, KEY_R,
                  output digits, Bit_Sel, changed, limit);

endinterface

// File: rtl/key_conditioner.sv
// Synchroniser, counter debounce and optional auto-repeat for one active-low key.
module key_conditioner
  import dds_ui_pkg::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000,
  parameter bit REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int DEB_LAST = (DEB_CYCLES > 1) ? DEB_CYCLES - 1 : 0;
  localparam int DEB_W    = sel_w(DEB_CYCLES + 1);
  localparam int REP_MAX  = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int REP_W    = sel_w(REP_MAX + 1);
  localparam bit REP_ON   = REPEAT_EN && (REP_PERIOD > 0);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'((REP_DELAY > 0) ? REP_DELAY - 1 : 0);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'((REP_PERIOD > 0) ? REP_PERIOD - 1 : 0);

  logic [1:0]       sync_q, sync_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             deb_q, deb_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_phase_q, rep_phase_d;
  logic             press_q, press_d;
  logic             lvl;
  logic             rep_fire;

  always_comb begin
    sync_d      = {sync_q[0], key_n};
    lvl         = ~sync_q[1];
    deb_d       = deb_q;
    deb_cnt_d   = '0;
    rep_cnt_d   = '0;
    rep_phase_d = 1'b0;
    rep_fire    = 1'b0;

    if (lvl != deb_q) begin
      if (deb_cnt_q == DEB_W'(DEB_LAST)) deb_d = lvl;
      else deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end

    // Repeat timer runs only across cycles where the key stays pressed;
    // the first interval is REP_DELAY, later ones REP_PERIOD.
    if (REP_ON && deb_q && deb_d) begin
      if (rep_cnt_q == (rep_phase_q ? PERIOD_LAST : DELAY_LAST)) begin
        rep_fire    = 1'b1;
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d   = rep_cnt_q + REP_W'(1);
        rep_phase_d = rep_phase_q;
      end
    end

    press_d = (deb_d && !deb_q) || rep_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b11;
      deb_cnt_q   <= '0;
      deb_q       <= 1'b0;
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      deb_cnt_q   <= deb_cnt_d;
      deb_q       <= deb_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
      press_q     <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/digit_editor.sv
// Key-driven digit editor: selects a digit with L/R and steps it with U/D.
module digit_editor
  import dds_ui_pkg::*;
#(
  parameter int          NUM_DIGITS = 4,
  parameter int          RADIX      = 10,
  parameter int          CARRY_MODE = 0,
  parameter int          DEB_CYCLES = 250000,
  parameter int          REP_DELAY  = 25000000,
  parameter int          REP_PERIOD = 5000000,
  parameter logic [31:0] RESET_VAL  = 32'h0
) (
  input logic           clk,
  input logic           rst,
  digit_editor_if.slave bus
);

  localparam int DW    = NUM_DIGITS * DIGIT_W;
  localparam int SEL_W = sel_w(NUM_DIGITS);
  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_DIGITS - 1);
  localparam logic [DIGIT_W-1:0] RADIX_LAST = DIGIT_W'(RADIX - 1);

  logic [3:0]         key_n;
  logic [3:0]         press;
  logic [DW-1:0]      digits_q, digits_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               changed_q, changed_d;
  logic               limit_q, limit_d;
  logic               u_ev, d_ev, l_ev, r_ev;
  logic [DIGIT_W-1:0] nib, nib_new;
  int                 sel_idx;
  step_t              step;
  logic               step_unused;

  assign key_n[K_U] = bus.KEY_U;
  assign key_n[K_D] = bus.KEY_D;
  assign key_n[K_L] = bus.KEY_L;
  assign key_n[K_R] = bus.KEY_R;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_conditioner #(
      .DEB_CYCLES(DEB_CYCLES),
      .REP_DELAY (REP_DELAY),
      .REP_PERIOD(REP_PERIOD),
      .REPEAT_EN (k == K_U || k == K_D)
    ) u_key (
      .clk  (clk),
      .rst  (rst),
      .key_n(key_n[k]),
      .press(press[k])
    );
  end

  assign step = carry_step(32'(digits_q), NUM_DIGITS, 5'(RADIX), int'(sel_q), d_ev);
  assign step_unused = ^step;

  always_comb begin
    u_ev      = press[K_U] & ~press[K_D];
    d_ev      = press[K_D] & ~press[K_U];
    l_ev      = press[K_L] & ~press[K_R];
    r_ev      = press[K_R] & ~press[K_L];
    sel_d     = sel_q;
    digits_d  = digits_q;
    limit_d   = 1'b0;
    sel_idx   = int'(sel_q);
    nib       = digits_q[sel_idx*DIGIT_W +: DIGIT_W];
    nib_new   = nib;

    if (l_ev) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
    else if (r_ev) sel_d = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);

    // Value step always uses the selection from before this cycle's L/R.
    if (u_ev || d_ev) begin
      if (CARRY_MODE != 0) begin
        if (step.ovf) limit_d = 1'b1;
        else digits_d = step.value[DW-1:0];
      end else begin
        if (u_ev) nib_new = (nib == RADIX_LAST) ? '0 : nib + DIGIT_W'(1);
        else nib_new = (nib == '0) ? RADIX_LAST : nib - DIGIT_W'(1);
        digits_d[sel_idx*DIGIT_W +: DIGIT_W] = nib_new;
      end
    end

    changed_d = (digits_d != digits_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q  <= RESET_VAL[DW-1:0];
      sel_q     <= '0;
      changed_q <= 1'b0;
      limit_q   <= 1'b0;
    end else begin
      digits_q  <= digits_d;
      sel_q     <= sel_d;
      changed_q <= changed_d;
      limit_q   <= limit_d;
    end
  end

  assign bus.digits  = digits_q;
  assign bus.Bit_Sel = sel_q;
  assign bus.changed = changed_q;
  assign bus.limit   = limit_q;

endmodule
